axis_wide2narrow_conv: RTL
==========================

// Module: axis_wide2narrow_conv
// PURPOSE
//  AXI-Stream width down-converter, 1:C_RATIO. Buffers wide input beats in an internal FIFO and emits C_RATIO narrow beats per wide beat.
//  On a TLAST beat, it emits only up to the highest lane with any TKEEP bit set.
//  Sits between the wide datapath (512b) and narrower MAC/parser ports. Supersedes the fixed 2:1 converter.
// PARAMETERS
//  C_WIDTH_TDATA   512             input TDATA width; must be divisible by 8*C_RATIO
//  C_WIDTH_TKEEP   C_WIDTH_TDATA/8 input TKEEP width
//  C_RATIO         2               narrow lanes per wide beat; power of two, 2..8
//  C_FIFO_DEPTH    16              input FIFO entries; power of two, >=4
//  C_NF_MARGIN     2               in_TREADY deasserts when free entries <= C_NF_MARGIN
// PORTS
//  clk           in   1                      clock; all logic on posedge
//  rst           in   1                      synchronous reset, active high
//  in_TVALID     in   1                      input beat valid
//  in_TREADY     out  1                      input ready (= !nearly_full)
//  in_TDATA      in   C_WIDTH_TDATA          input data; lane k = bits [(k+1)*W/R-1 : k*W/R]
//  in_TKEEP      in   C_WIDTH_TKEEP          input byte enables
//  in_TLAST      in   1                      end of packet
//  out_TVALID    out  1                      narrow beat valid
//  out_TREADY    in   1                      downstream ready
//  out_TDATA     out  C_WIDTH_TDATA/C_RATIO  narrow data
//  out_TKEEP     out  C_WIDTH_TKEEP/C_RATIO  narrow byte enables
//  out_TLAST     out  1                      end of packet
//  err_sparse    out  1                      sticky: non-last input beat with TKEEP != all ones
//  pkt_count     out  32                     count of out_TLAST handshakes; wraps at 2^32
// BEHAVIOUR
//  Reset
//   - Clears the FIFO and the lane counter.
//   - Drives out_TVALID=0, out_TLAST=0, out_TDATA=0, out_TKEEP=0, err_sparse=0, pkt_count=0.
//   - in_TREADY=1 the cycle after rst falls.
//   - Reset mid-packet discards all buffered and partially emitted data; there is no flush.
//  Input
//   - Writes occur only on in_TVALID && in_TREADY. A beat with in_TREADY=0 is never written.
//   - The C_NF_MARGIN slack is for upstream pipelines only.
//  Output register
//   - out_* are registered. Once out_TVALID=1, out_* hold stable until out_TREADY=1.
//  Latency
//   - An input handshake in cycle t into an empty FIFO gives out_TVALID=1 in cycle t+2.
//  Throughput
//   - One narrow beat per cycle while out_TREADY=1 and the FIFO is non-empty.
//   - No bubble between wide beats or between packets.
//  FSM: S_IDLE, S_SEND
//   - S_IDLE: FIFO non-empty -> load lane 0 of the head entry, lane=0, go to S_SEND.
//   - S_SEND: out handshake with lane < last_lane -> load lane+1.
//   - S_SEND: out handshake with lane == last_lane -> pop the FIFO head.
//       - FIFO still non-empty (counting the same-cycle pop) -> load lane 0 of the next entry, stay in S_SEND.
//       - otherwise out_TVALID=0, go to S_IDLE.
//   - No handshake -> hold.
//  last_lane
//   - Non-last beat: C_RATIO-1.
//   - TLAST beat: index of the highest lane with any TKEEP bit set.
//   - TLAST beat with TKEEP all zero: 0, so one lane-0 beat is emitted with TKEEP=0 and TLAST=1.
//  out_TLAST = head TLAST && (lane == last_lane). out_TKEEP = TKEEP slice of the current lane.
//  err_sparse: set when a non-last head entry is loaded with TKEEP != all ones. Cleared only by rst. The data is still emitted unchanged.
//  pkt_count: +1 on each out_TVALID && out_TREADY && out_TLAST; wraps from 0xFFFFFFFF to 0.
//  Simultaneous write and pop in the same cycle: FIFO occupancy is unchanged.
//  Full FIFO with a same-cycle pop: no write occurs, because in_TREADY is already 0.
// TESTING
//  T1 R=2
//   - Stimulus: one 512b beat, TLAST=1, TKEEP all ones, out_TREADY=1.
//   - Expect: 2 beats, lane0 then lane1; TLAST only on the 2nd; pkt_count=1; first out_TVALID at t+2.
//  T2 R=4
//   - Stimulus: TLAST beat with TKEEP=64'h0000_0000_00FF_FFFF.
//   - Expect: exactly 2 beats; 2nd beat TKEEP=16'h00FF with TLAST=1.
//  T3 R=2
//   - Stimulus: 20 back-to-back beats while out_TREADY is held low.
//   - Expect: in_TREADY falls at 14 entries (16-2); no beat lost; after release, 40 ordered beats, no bubbles.
//  T4
//   - Stimulus: random out_TREADY toggling (50%) over 1000 random-length packets.
//   - Expect: output byte stream equals input; out_* stable while stalled; pkt_count=1000.
//  T5
//   - Stimulus: non-last beat with TKEEP=64'hFFFF_FFFF_FFFF_FFFE.
//   - Expect: err_sparse=1 after the beat loads; stays 1 until rst.
//  T6
//   - Stimulus: assert rst mid-packet, with lane 1 of 2 pending.
//   - Expect: next cycle out_TVALID=0, FIFO empty, pkt_count=0; the next packet converts correctly.

Source files
------------

// File: rtl/axis_wide2narrow_conv.sv
// ---------------------------------------------------------------------------
// axis_wide2narrow_conv
//   AXI-Stream width down-converter (1:C_RATIO). Wide input beats are queued
//   in an internal FIFO. Each queued beat is emitted as up to C_RATIO narrow
//   beats, lane 0 first. On a TLAST beat, emission stops at the highest lane
//   that has any TKEEP bit set; a TLAST beat with no TKEEP bits set still
//   produces one lane-0 beat.
//
//   Handshake rule for both streams: a beat transfers on a rising clk edge
//   where TVALID and TREADY are both 1. Once out_TVALID is 1, out_TVALID and
//   out_TDATA/out_TKEEP/out_TLAST hold until that transfer happens.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   in_*         wide AXI-Stream slave; in_TREADY drops when the FIFO has
//                C_NF_MARGIN or fewer free entries
//   out_*        narrow AXI-Stream master, fully registered
//   err_sparse   sticky flag: a non-last beat with a partial TKEEP was loaded
//   pkt_count    number of out_TLAST transfers, wraps at 2^32
// ---------------------------------------------------------------------------
module axis_wide2narrow_conv #(
   parameter int C_WIDTH_TDATA = 512,
   parameter int C_WIDTH_TKEEP = C_WIDTH_TDATA / 8,
   parameter int C_RATIO       = 2,
   parameter int C_FIFO_DEPTH  = 16,
   parameter int C_NF_MARGIN   = 2
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               in_TVALID,
   output logic                               in_TREADY,
   input  logic [C_WIDTH_TDATA-1:0]           in_TDATA,
   input  logic [C_WIDTH_TKEEP-1:0]           in_TKEEP,
   input  logic                               in_TLAST,
   output logic                               out_TVALID,
   input  logic                               out_TREADY,
   output logic [C_WIDTH_TDATA/C_RATIO-1:0]   out_TDATA,
   output logic [C_WIDTH_TKEEP/C_RATIO-1:0]   out_TKEEP,
   output logic                               out_TLAST,
   output logic                               err_sparse,
   output logic [31:0]                        pkt_count
);

   localparam int LW  = C_WIDTH_TDATA / C_RATIO;
   localparam int LKW = C_WIDTH_TKEEP / C_RATIO;
   localparam int AW  = $clog2(C_FIFO_DEPTH);
   localparam int CW  = AW + 1;
   localparam int LNW = $clog2(C_RATIO);

   typedef enum logic {S_IDLE, S_SEND} state_t;

   // FIFO storage (no reset needed: occupancy is tracked by count_q)
   logic [C_WIDTH_TDATA-1:0] mem_data_q [C_FIFO_DEPTH];
   logic [C_WIDTH_TKEEP-1:0] mem_keep_q [C_FIFO_DEPTH];
   logic                     mem_last_q [C_FIFO_DEPTH];

   logic [AW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, nxt_ptr;
   logic [CW-1:0]  count_q, count_d, free_cnt;
   state_t         state_q, state_d;
   logic [LNW-1:0] lane_q, lane_d, last_lane_q, last_lane_d;
   logic [LNW-1:0] ld_lane, ld_last_lane;
   logic           out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic [LW-1:0]  out_data_q, out_data_d;
   logic [LKW-1:0] out_keep_q, out_keep_d;
   logic           err_q, err_d;
   logic [31:0]    pkt_q, pkt_d;

   logic                     wr_en, pop, load, out_hs;
   logic [C_WIDTH_TDATA-1:0] src_data;
   logic [C_WIDTH_TKEEP-1:0] src_keep;
   logic                     src_last;

   // Last lane to emit for a wide beat.
   function automatic logic [LNW-1:0] calc_last_lane(input logic [C_WIDTH_TKEEP-1:0] keep,
                                                     input logic last);
      logic [LNW-1:0] ll;
      ll = LNW'(C_RATIO - 1);
      if (last) begin
         ll = '0;
         for (int k = 0; k < C_RATIO; k++) begin
            if (|keep[k*LKW +: LKW]) ll = LNW'(k);
         end
      end
      return ll;
   endfunction

   assign free_cnt  = CW'(C_FIFO_DEPTH) - count_q;
   assign in_TREADY = (free_cnt > CW'(C_NF_MARGIN));

   always_comb begin
      wr_en   = in_TVALID && in_TREADY;
      out_hs  = out_valid_q && out_TREADY;
      nxt_ptr = rd_ptr_q + AW'(1);

      state_d      = state_q;
      lane_d       = lane_q;
      last_lane_d  = last_lane_q;
      out_valid_d  = out_valid_q;
      out_last_d   = out_last_q;
      out_data_d   = out_data_q;
      out_keep_d   = out_keep_q;
      err_d        = err_q;
      pop          = 1'b0;
      load         = 1'b0;
      ld_lane      = '0;
      ld_last_lane = last_lane_q;
      src_data     = mem_data_q[rd_ptr_q];
      src_keep     = mem_keep_q[rd_ptr_q];
      src_last     = mem_last_q[rd_ptr_q];

      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               load    = 1'b1;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (out_hs) begin
               if (lane_q != last_lane_q) begin
                  load    = 1'b1;
                  ld_lane = lane_q + LNW'(1);
               end else begin
                  pop = 1'b1;
                  if (count_q > CW'(1) || wr_en) begin
                     // Next entry is either already queued behind the head,
                     // or is being written this very cycle into an otherwise
                     // empty FIFO; taking it from the input avoids a bubble.
                     load = 1'b1;
                     if (count_q > CW'(1)) begin
                        src_data = mem_data_q[nxt_ptr];
                        src_keep = mem_keep_q[nxt_ptr];
                        src_last = mem_last_q[nxt_ptr];
                     end else begin
                        src_data = in_TDATA;
                        src_keep = in_TKEEP;
                        src_last = in_TLAST;
                     end
                  end else begin
                     out_valid_d = 1'b0;
                     out_last_d  = 1'b0;
                     state_d     = S_IDLE;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (load) begin
         if (ld_lane == '0) ld_last_lane = calc_last_lane(src_keep, src_last);
         lane_d      = ld_lane;
         last_lane_d = ld_last_lane;
         out_valid_d = 1'b1;
         out_data_d  = src_data[int'(ld_lane)*LW +: LW];
         out_keep_d  = src_keep[int'(ld_lane)*LKW +: LKW];
         out_last_d  = src_last && (ld_lane == ld_last_lane);
         if (ld_lane == '0 && !src_last && src_keep != '1) err_d = 1'b1;
      end

      pkt_d    = pkt_q + {31'd0, out_hs && out_last_q};
      count_d  = count_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
      wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? nxt_ptr : rd_ptr_q;
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_data_q[wr_ptr_q] <= in_TDATA;
         mem_keep_q[wr_ptr_q] <= in_TKEEP;
         mem_last_q[wr_ptr_q] <= in_TLAST;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         lane_q      <= '0;
         last_lane_q <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         err_q       <= 1'b0;
         pkt_q       <= '0;
      end else begin
         state_q     <= state_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         lane_q      <= lane_d;
         last_lane_q <= last_lane_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
         out_keep_q  <= out_keep_d;
         err_q       <= err_d;
         pkt_q       <= pkt_d;
      end
   end

   assign out_TVALID = out_valid_q;
   assign out_TLAST  = out_last_q;
   assign out_TDATA  = out_data_q;
   assign out_TKEEP  = out_keep_q;
   assign err_sparse = err_q;
   assign pkt_count  = pkt_q;

endmodule
